// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline (master) and the hazard controller (slave).
// Names ending in _i are driven by the pipeline; names ending in _o are driven by the controller.
interface hazard_ctrl_if;
  logic [4:0]  rs1_raddr_i;
  logic [4:0]  rs2_raddr_i;
  logic        rs1_ren_i;
  logic        rs2_ren_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_rd_wen_i;
  logic        ex_is_load_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        bus_req_i;
  logic        bus_ack_i;
  logic        hold_pc_o;
  logic        hold_if_id_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        bus_grant_o;
  logic        bus_timeout_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output rs1_raddr_i, rs2_raddr_i, rs1_ren_i, rs2_ren_i,
           ex_rd_addr_i, ex_rd_wen_i, ex_is_load_i,
           jump_en_i, jump_addr_i, bus_req_i, bus_ack_i,
    input  hold_pc_o, hold_if_id_o, flush_if_id_o, flush_id_ex_o,
           jump_en_o, jump_addr_o, bus_grant_o, bus_timeout_o, stall_cnt_o
  );

  modport slave (
    input  rs1_raddr_i, rs2_raddr_i, rs1_ren_i, rs2_ren_i,
           ex_rd_addr_i, ex_rd_wen_i, ex_is_load_i,
           jump_en_i, jump_addr_i, bus_req_i, bus_ack_i,
    output hold_pc_o, hold_if_id_o, flush_if_id_o, flush_id_ex_o,
           jump_en_o, jump_addr_o, bus_grant_o, bus_timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, jump flush and external bus hold with timeout.
//   state    | meaning
//   IDLE     | normal flow; jump > bus request > load-use
//   LU_STALL | second load-use bubble, then back to IDLE
//   BUS_HOLD | pipeline frozen, bus granted until ack or timeout
module hazard_ctrl #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam int TW = $clog2(BUS_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LU_STALL, BUS_HOLD} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_tcnt;
  logic            r_timeout;
  logic [31:0]     r_stall_cnt;

  logic            w_load_use;
  logic            w_to;
  logic            w_hold;
  logic            w_flush_if_id;
  logic            w_flush_id_ex;
  logic            w_jump_en;
  logic [31:0]     w_jump_addr;
  logic            w_grant;

  assign w_load_use = hz.ex_is_load_i & hz.ex_rd_wen_i & (hz.ex_rd_addr_i != 5'd0) &
                      ((hz.rs1_ren_i & (hz.rs1_raddr_i == hz.ex_rd_addr_i)) |
                       (hz.rs2_ren_i & (hz.rs2_raddr_i == hz.ex_rd_addr_i)));

  assign w_to = (r_tcnt == TW'(BUS_TIMEOUT - 1));

  always_comb begin
    w_next        = r_state;
    w_hold        = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    w_jump_en     = 1'b0;
    w_jump_addr   = 32'd0;
    w_grant       = 1'b0;
    // Reset shows the IDLE decode so the pipeline sees sane controls immediately.
    if (rst || r_state == IDLE) begin
      if (hz.jump_en_i) begin
        w_jump_en     = 1'b1;
        w_jump_addr   = hz.jump_addr_i;
        w_flush_if_id = 1'b1;
        w_flush_id_ex = 1'b1;
        w_next        = IDLE;
      end else if (hz.bus_req_i) begin
        w_hold        = 1'b1;
        w_flush_id_ex = 1'b1;
        w_next        = BUS_HOLD;
      end else if (w_load_use) begin
        w_hold        = 1'b1;
        w_flush_id_ex = 1'b1;
        w_next        = LU_STALL;
      end else begin
        w_next        = IDLE;
      end
    end else if (r_state == LU_STALL) begin
      w_next = IDLE;
      if (hz.jump_en_i) begin
        w_jump_en     = 1'b1;
        w_jump_addr   = hz.jump_addr_i;
        w_flush_if_id = 1'b1;
        w_flush_id_ex = 1'b1;
      end else begin
        w_hold        = 1'b1;
        w_flush_id_ex = 1'b1;
      end
    end else if (r_state == BUS_HOLD) begin
      w_grant       = 1'b1;
      w_hold        = 1'b1;
      w_flush_id_ex = 1'b1;
      if (hz.bus_ack_i || w_to) begin
        w_next = IDLE;
      end
    end else begin
      w_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tcnt      <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_state   <= w_next;
      r_timeout <= (r_state == BUS_HOLD) && w_to && !hz.bus_ack_i;
      if (r_state != BUS_HOLD) begin
        r_tcnt <= '0;
      end else if (!w_to) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_hold && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign hz.hold_pc_o     = w_hold;
  assign hz.hold_if_id_o  = w_hold;
  assign hz.flush_if_id_o = w_flush_if_id;
  assign hz.flush_id_ex_o = w_flush_id_ex;
  assign hz.jump_en_o     = w_jump_en;
  assign hz.jump_addr_o   = w_jump_addr;
  assign hz.bus_grant_o   = w_grant;
  assign hz.bus_timeout_o = r_timeout;
  assign hz.stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one instance at the default timeout, one with BUS_TIMEOUT=4.
// Each driven cycle queues its hand-computed outputs; the monitor compares on the falling edge.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if ia ();
  hazard_ctrl_if ib ();

  hazard_ctrl dut_a (.clk(clk), .rst(rst), .hz(ia.slave));
  hazard_ctrl #(.BUS_TIMEOUT(4)) dut_b (.clk(clk), .rst(rst), .hz(ib.slave));

  // {hold_pc, hold_if_id, flush_if_id, flush_id_ex, jump_en, grant, timeout, jump_addr, stall_cnt}
  typedef struct {
    string       nm;
    bit          sel;
    logic [70:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [70:0] mk(input bit hold, input bit fid, input bit fex, input bit jen,
                                     input logic [31:0] ja, input bit gnt, input bit to,
                                     input logic [31:0] sc);
    return {hold, hold, fid, fex, jen, gnt, to, ja, sc};
  endfunction

  function automatic logic [70:0] act_a();
    return {ia.hold_pc_o, ia.hold_if_id_o, ia.flush_if_id_o, ia.flush_id_ex_o, ia.jump_en_o,
            ia.bus_grant_o, ia.bus_timeout_o, ia.jump_addr_o, ia.stall_cnt_o};
  endfunction

  function automatic logic [70:0] act_b();
    return {ib.hold_pc_o, ib.hold_if_id_o, ib.flush_if_id_o, ib.flush_id_ex_o, ib.jump_en_o,
            ib.bus_grant_o, ib.bus_timeout_o, ib.jump_addr_o, ib.stall_cnt_o};
  endfunction

  initial begin : monitor
    exp_t        e;
    logic [70:0] a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = e.sel ? act_b() : act_a();
        n_chk++;
        if (a === e.v) n_pass++;
        else $display("FAIL %s: got %h expected %h", e.nm, a, e.v);
      end
    end
  end

  task automatic step(input string nm, input bit sel, input logic [70:0] v);
    exp_t e;
    e.nm  = nm;
    e.sel = sel;
    e.v   = v;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ia.rs1_raddr_i = 5'd0; ia.rs2_raddr_i = 5'd0; ia.rs1_ren_i = 1'b0; ia.rs2_ren_i = 1'b0;
    ia.ex_rd_addr_i = 5'd0; ia.ex_rd_wen_i = 1'b0; ia.ex_is_load_i = 1'b0;
    ia.jump_en_i = 1'b0; ia.jump_addr_i = 32'd0; ia.bus_req_i = 1'b0; ia.bus_ack_i = 1'b0;
    ib.rs1_raddr_i = 5'd0; ib.rs2_raddr_i = 5'd0; ib.rs1_ren_i = 1'b0; ib.rs2_ren_i = 1'b0;
    ib.ex_rd_addr_i = 5'd0; ib.ex_rd_wen_i = 1'b0; ib.ex_is_load_i = 1'b0;
    ib.jump_en_i = 1'b0; ib.jump_addr_i = 32'd0; ib.bus_req_i = 1'b0; ib.bus_ack_i = 1'b0;
  endtask

  task automatic load_a(input logic [4:0] rd, input bit wen, input logic [4:0] r1, input bit e1,
                        input logic [4:0] r2, input bit e2);
    ia.ex_is_load_i = 1'b1; ia.ex_rd_addr_i = rd; ia.ex_rd_wen_i = wen;
    ia.rs1_raddr_i = r1; ia.rs1_ren_i = e1; ia.rs2_raddr_i = r2; ia.rs2_ren_i = e2;
  endtask

  initial begin : driver
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("reset_idle", 0, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd0));
    ia.bus_req_i = 1'b1;
    step("reset_idle_decode", 0, mk(1, 0, 1, 0, 32'd0, 0, 0, 32'd0));
    rst = 1'b0;
    clr();
    step("post_reset", 0, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd0));

    // load-use filtered out
    load_a(5'd0, 1, 5'd0, 1, 5'd0, 1);
    step("lu_rd0", 0, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd0));
    load_a(5'd5, 1, 5'd5, 0, 5'd5, 0);
    step("lu_no_ren", 0, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd0));
    load_a(5'd5, 0, 5'd3, 1, 5'd5, 1);
    step("lu_no_wen", 0, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd0));
    clr();
    ia.ex_rd_addr_i = 5'd5; ia.ex_rd_wen_i = 1'b1; ia.rs2_raddr_i = 5'd5; ia.rs2_ren_i = 1'b1;
    step("lu_not_load", 0, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd0));

    // two-bubble load-use on rs2
    clr();
    load_a(5'd5, 1, 5'd1, 1, 5'd5, 1);
    step("lu_bubble1", 0, mk(1, 0, 1, 0, 32'd0, 0, 0, 32'd0));
    step("lu_bubble2", 0, mk(1, 0, 1, 0, 32'd0, 0, 0, 32'd1));
    clr();
    step("lu_done", 0, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd2));

    // load-use on rs1, jump overrides the second bubble
    load_a(5'd7, 1, 5'd7, 1, 5'd2, 0);
    step("lu_rs1", 0, mk(1, 0, 1, 0, 32'd0, 0, 0, 32'd2));
    clr();
    ia.jump_en_i = 1'b1; ia.jump_addr_i = 32'h0000_0200;
    step("lu_jump", 0, mk(0, 1, 1, 1, 32'h0000_0200, 0, 0, 32'd3));
    clr();
    step("lu_jump_done", 0, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd3));

    // jump beats bus request; bus held next, jump ignored in BUS_HOLD
    ia.jump_en_i = 1'b1; ia.jump_addr_i = 32'h0000_0100; ia.bus_req_i = 1'b1;
    step("jump_vs_bus", 0, mk(0, 1, 1, 1, 32'h0000_0100, 0, 0, 32'd3));
    ia.jump_en_i = 1'b0; ia.jump_addr_i = 32'd0;
    step("bus_after_jump", 0, mk(1, 0, 1, 0, 32'd0, 0, 0, 32'd3));
    ia.bus_req_i = 1'b0;
    step("bus_hold1", 0, mk(1, 0, 1, 0, 32'd0, 1, 0, 32'd4));
    ia.jump_en_i = 1'b1; ia.jump_addr_i = 32'h0000_0300;
    step("bus_jump_ignored", 0, mk(1, 0, 1, 0, 32'd0, 1, 0, 32'd5));
    clr();
    ia.bus_ack_i = 1'b1;
    step("bus_ack", 0, mk(1, 0, 1, 0, 32'd0, 1, 0, 32'd6));
    clr();
    step("bus_release", 0, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd7));

    // bus request pulse, ack on the 10th held cycle
    ia.bus_req_i = 1'b1;
    step("bus10_req", 0, mk(1, 0, 1, 0, 32'd0, 0, 0, 32'd7));
    ia.bus_req_i = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      ia.bus_ack_i = (i == 10);
      step($sformatf("bus10_hold%0d", i), 0, mk(1, 0, 1, 0, 32'd0, 1, 0, 32'(7 + i)));
    end
    clr();
    step("bus10_idle", 0, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd18));

    // reset in the middle of BUS_HOLD
    ia.bus_req_i = 1'b1;
    step("rst_bus_req", 0, mk(1, 0, 1, 0, 32'd0, 0, 0, 32'd18));
    ia.bus_req_i = 1'b0;
    step("rst_bus_hold", 0, mk(1, 0, 1, 0, 32'd0, 1, 0, 32'd19));
    rst = 1'b1;
    step("rst_asserted", 0, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd20));
    rst = 1'b0;
    step("rst_after", 0, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd0));

    // BUS_TIMEOUT=4 instance: no ack -> release after 4 held cycles with one pulse
    ib.bus_req_i = 1'b1;
    step("to_req", 1, mk(1, 0, 1, 0, 32'd0, 0, 0, 32'd0));
    ib.bus_req_i = 1'b0;
    for (int i = 1; i <= 4; i++)
      step($sformatf("to_hold%0d", i), 1, mk(1, 0, 1, 0, 32'd0, 1, 0, 32'(i)));
    step("to_pulse", 1, mk(0, 0, 0, 0, 32'd0, 0, 1, 32'd5));
    step("to_pulse_end", 1, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd5));

    // ack coinciding with the timeout cycle wins, no pulse
    ib.bus_req_i = 1'b1;
    step("ackto_req", 1, mk(1, 0, 1, 0, 32'd0, 0, 0, 32'd5));
    ib.bus_req_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ib.bus_ack_i = (i == 4);
      step($sformatf("ackto_hold%0d", i), 1, mk(1, 0, 1, 0, 32'd0, 1, 0, 32'(5 + i)));
    end
    clr();
    step("ackto_idle", 1, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd10));
    step("ackto_idle2", 1, mk(0, 0, 0, 0, 32'd0, 0, 0, 32'd10));

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 255: maximum cycles in BUS_HOLD before forced release.
REQ-002 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have rs1_raddr_i, rs2_raddr_i  input  5 each  source register addresses of the instruction in ID.
REQ-005 SHALL have rs1_ren_i, rs2_ren_i  input  1 each  source register actually read by the ID instruction.
REQ-006 SHALL have ex_rd_addr_i  input  5, ex_rd_wen_i  input  1, ex_is_load_i  input  1  destination info of the instruction in EX.
REQ-007 SHALL have jump_en_i  input  1, jump_addr_i  input  32  taken branch/jump resolved in EX.
REQ-008 SHALL have bus_req_i  input  1, bus_ack_i  input  1  external bus-master request and completion.
REQ-009 SHALL have hold_pc_o, hold_if_id_o  output  1 each  freeze PC and IF/ID register.
REQ-010 SHALL have flush_if_id_o, flush_id_ex_o  output  1 each  load NOP into IF/ID or ID/EX.
REQ-011 SHALL have jump_en_o  output  1, jump_addr_o  output  32  PC redirect.
REQ-012 SHALL have bus_grant_o  output  1, bus_timeout_o  output  1  bus ownership and timeout pulse.
REQ-013 SHALL have stall_cnt_o  output  32  count of cycles with hold_pc_o=1.

Function
REQ-014 SHALL implement states IDLE, LU_STALL, BUS_HOLD in a registered state variable; all outputs except stall_cnt_o and bus_timeout_o are combinational from state and inputs.
REQ-015 load_use SHALL equal ex_is_load_i & ex_rd_wen_i & (ex_rd_addr_i!=0) & ((rs1_ren_i & rs1_raddr_i==ex_rd_addr_i) | (rs2_ren_i & rs2_raddr_i==ex_rd_addr_i)).
REQ-016 In IDLE, priority SHALL be jump_en_i > bus_req_i > load_use.
REQ-017 IDLE with jump_en_i: jump_en_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1, no hold, next IDLE.
REQ-018 IDLE with bus_req_i (no jump): hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1, next BUS_HOLD.
REQ-019 IDLE with load_use only: hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1, next LU_STALL (total load-use penalty exactly 2 bubbles; no MEM->EX forwarding).
REQ-020 LU_STALL: same three outputs as REQ-019 for one cycle, then IDLE unconditionally; if jump_en_i=1 here, REQ-017 behaviour overrides.
REQ-021 BUS_HOLD: bus_grant_o=1, hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1; jump_en_i ignored; bus_ack_i=1 -> next IDLE.
REQ-022 A timeout counter SHALL clear on BUS_HOLD entry and increment each BUS_HOLD cycle; when it reaches BUS_TIMEOUT without ack, next state SHALL be IDLE and bus_timeout_o SHALL pulse high one cycle (registered, visible the first IDLE cycle).
REQ-023 bus_ack_i and timeout in the same cycle: treat as ack, no timeout pulse.
REQ-024 jump_addr_o SHALL be 0 whenever jump_en_o=0; all other outputs default 0 when not driven high.
REQ-025 stall_cnt_o SHALL increment by 1 on every cycle with hold_pc_o=1 and saturate at 32'hFFFF_FFFF.

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE, timeout counter 0, bus_timeout_o 0, stall_cnt_o 0, overriding any operation in progress, including mid BUS_HOLD or LU_STALL.
REQ-027 While rst=1, combinational outputs SHALL follow IDLE decode; bus_grant_o SHALL be 0.

Verification
REQ-028 Load x5 in EX (ex_is_load_i=1, ex_rd_addr_i=5, wen=1), ID rs2=5 ren=1 -> hold_pc_o/flush_id_ex_o high 2 consecutive cycles, stall_cnt_o=2, then IDLE.
REQ-029 Same with ex_rd_addr_i=0 or rs2_ren_i=0 -> no hold, stall_cnt_o stays 0.
REQ-030 jump_en_i=1, jump_addr_i=0x0000_0100 with bus_req_i=1 same cycle -> jump_en_o=1, addr 0x100, both flushes; BUS_HOLD entered next cycle.
REQ-031 bus_req_i pulse, ack after 10 cycles -> bus_grant_o high 10 cycles, stall_cnt_o=11, IDLE after ack.
REQ-032 BUS_TIMEOUT=4, never ack -> after 4 BUS_HOLD cycles return to IDLE, bus_timeout_o one-cycle pulse.
REQ-033 rst=1 mid BUS_HOLD -> next cycle IDLE, bus_grant_o=0, stall_cnt_o=0.
